// File: rtl/panel_write_arbiter.sv
// rtl/panel_write_arbiter.sv - two-source write arbiter with built-in fill sequencer for the LED panel video memory
//
// Purpose:
//   Shares the panel video-memory write port between requester A (network
//   frame receiver) and requester B (control CPU). It also contains a fill
//   sequencer that paints every framebuffer entry with one colour. All outputs
//   to the panel are registered. Everything runs on the rising edge of
//   i_ctrl_clk.
//
// Ports:
//   i_ctrl_clk            sole clock
//   i_reset               synchronous, active-high reset
//   i_a_valid/o_a_ready   requester A handshake (transfer = valid & ready)
//   i_a_addr/mask/data    A pixel address {row,col}, {R,G,B} enables, [R][G][B] data
//   i_b_*/o_b_ready       same for requester B
//   i_fill_start          single-cycle fill request (ignored while filling)
//   i_fill_color          fill colour, sampled with i_fill_start
//   o_fill_busy           fill in progress
//   o_fill_done           one-cycle pulse coincident with the last fill write
//   o_drop_count          saturating count of accepted out-of-range writes
//   o_ctrl_en/wr/addr/wdat  registered write port into ledpanel

module panel_write_arbiter #(
    parameter int CHAINED = 2
) (
    input  logic        i_ctrl_clk,
    input  logic        i_reset,

    input  logic        i_a_valid,
    output logic        o_a_ready,
    input  logic [15:0] i_a_addr,
    input  logic [2:0]  i_a_mask,
    input  logic [23:0] i_a_data,

    input  logic        i_b_valid,
    output logic        o_b_ready,
    input  logic [15:0] i_b_addr,
    input  logic [2:0]  i_b_mask,
    input  logic [23:0] i_b_data,

    input  logic        i_fill_start,
    input  logic [23:0] i_fill_color,
    output logic        o_fill_busy,
    output logic        o_fill_done,
    output logic [7:0]  o_drop_count,

    output logic        o_ctrl_en,
    output logic [3:0]  o_ctrl_wr,
    output logic [15:0] o_ctrl_addr,
    output logic [23:0] o_ctrl_wdat
);

    localparam int          DEPTH     = CHAINED * 4096;
    // 17-bit compare so CHAINED=16 (DEPTH=65536) still works
    localparam logic [16:0] DEPTH_W   = 17'(DEPTH);
    localparam logic [15:0] LAST_ADDR = 16'(DEPTH - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_t;

    state_t      r_state;
    logic        r_last_grant_b;   // 1: B was granted most recently
    logic [15:0] r_fill_cnt;
    logic [23:0] r_fill_color;
    logic        r_fill_busy;
    logic        r_fill_done;
    logic [7:0]  r_drop_count;
    logic        r_ctrl_en;
    logic [3:0]  r_ctrl_wr;
    logic [15:0] r_ctrl_addr;
    logic [23:0] r_ctrl_wdat;

    logic        w_idle;
    logic        w_grant_a;
    logic        w_grant_b;
    logic        w_xfer;
    logic [15:0] w_sel_addr;
    logic [2:0]  w_sel_mask;
    logic [23:0] w_sel_data;
    logic        w_in_range;

    // Arbitration. Grants are gated with reset so ready reads 0 during reset.
    // Each grant already includes its own valid, so ready never rises without
    // valid. On a tie the requester that did not win last time is granted.
    always_comb begin
        w_idle     = (r_state == ST_IDLE) && !i_reset;
        w_grant_a  = w_idle && i_a_valid && (!i_b_valid || r_last_grant_b);
        w_grant_b  = w_idle && i_b_valid && (!i_a_valid || !r_last_grant_b);
        w_xfer     = w_grant_a || w_grant_b;
        w_sel_addr = w_grant_a ? i_a_addr : i_b_addr;
        w_sel_mask = w_grant_a ? i_a_mask : i_b_mask;
        w_sel_data = w_grant_a ? i_a_data : i_b_data;
        w_in_range = ({1'b0, w_sel_addr} < DEPTH_W);
    end

    assign o_a_ready    = w_grant_a;
    assign o_b_ready    = w_grant_b;
    assign o_fill_busy  = r_fill_busy;
    assign o_fill_done  = r_fill_done;
    assign o_drop_count = r_drop_count;
    assign o_ctrl_en    = r_ctrl_en;
    assign o_ctrl_wr    = r_ctrl_wr;
    assign o_ctrl_addr  = r_ctrl_addr;
    assign o_ctrl_wdat  = r_ctrl_wdat;

    always_ff @(posedge i_ctrl_clk) begin
        if (i_reset) begin
            r_state        <= ST_IDLE;
            r_last_grant_b <= 1'b1;
            r_fill_cnt     <= '0;
            r_fill_color   <= '0;
            r_fill_busy    <= 1'b0;
            r_fill_done    <= 1'b0;
            r_drop_count   <= '0;
            r_ctrl_en      <= 1'b0;
            r_ctrl_wr      <= '0;
            r_ctrl_addr    <= '0;
            r_ctrl_wdat    <= '0;
        end else begin
            // Strobes default low; address/data hold when nothing is written.
            r_ctrl_en   <= 1'b0;
            r_ctrl_wr   <= '0;
            r_fill_done <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_xfer) begin
                        r_last_grant_b <= w_grant_b;
                        r_ctrl_addr    <= w_sel_addr;
                        r_ctrl_wdat    <= w_sel_data;
                        r_ctrl_wr      <= {1'b0, w_sel_mask};
                        // A zero mask is consumed without a strobe and is
                        // not a drop; out-of-range is dropped and counted.
                        r_ctrl_en      <= w_in_range && (w_sel_mask != 3'b000);
                        if (!w_in_range && (r_drop_count != 8'hFF))
                            r_drop_count <= r_drop_count + 8'd1;
                    end
                    // A grant in the same cycle as fill_start still completes.
                    if (i_fill_start) begin
                        r_fill_color <= i_fill_color;
                        r_fill_cnt   <= '0;
                        r_fill_busy  <= 1'b1;
                        r_state      <= ST_FILL;
                    end
                end

                ST_FILL: begin
                    r_ctrl_en   <= 1'b1;
                    r_ctrl_wr   <= 4'b0111;
                    r_ctrl_addr <= r_fill_cnt;
                    r_ctrl_wdat <= r_fill_color;
                    r_fill_cnt  <= r_fill_cnt + 16'd1;
                    // done lands together with the last write on the port
                    if (r_fill_cnt == LAST_ADDR) begin
                        r_fill_busy <= 1'b0;
                        r_fill_done <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
